// File: rtl/fetch_unit_pkg.sv
// Shared core package for the instruction-fetch stage.
// Holds the fetch state encoding, the canonical NOP used by both the fetch
// stage and the IF/ID flush path, and the default reset PC.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,  // ready to issue a cache request
    S_WAIT    = 2'd1,  // one request outstanding, waiting for its response
    S_DISCARD = 2'd2   // redirected while waiting; the response will be dropped
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// IF stage of the RV32I cached core.
// Keeps the PC, issues at most one instruction-cache request at a time,
// buffers the returned instruction until the IF/ID register takes it, and
// handles branch/jump redirects (including dropping an in-flight response).
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   stall             IF/ID register holds this cycle
//   jb, jb_target     redirect request from EX and its target address
//   ic_req_valid/addr cache request (word aligned), accepted with ic_req_ready
//   ic_resp_valid/data one response per accepted request
//   F_out_inst/pc     instruction and its PC presented to IF/ID
//   waiting           no valid instruction held; IF/ID should hold
module fetch_unit #(
  parameter logic [31:0] RESET_PC = fetch_unit_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = fetch_unit_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jb,
  input  logic [31:0] jb_target,
  output logic        ic_req_valid,
  output logic [31:0] ic_req_addr,
  input  logic        ic_req_ready,
  input  logic        ic_resp_valid,
  input  logic [31:0] ic_resp_data,
  output logic [31:0] F_out_inst,
  output logic [31:0] F_out_pc,
  output logic        waiting
);
  import fetch_unit_pkg::*;

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_pend_pc;
  logic [31:0]  r_hold_inst;
  logic [31:0]  r_hold_pc;
  logic         r_hold_valid;

  logic         w_consume;
  logic         w_req_fire;
  logic [31:0]  w_jb_pc;

  // IF/ID takes the held instruction unless stalled; a redirect kills it.
  assign w_consume  = r_hold_valid && !stall && !jb;
  assign w_req_fire = ic_req_valid && ic_req_ready;
  assign w_jb_pc    = {jb_target[31:2], 2'b00};

  // A new request may only go out once the hold buffer is free (or freed this
  // cycle). rst gates the request so nothing is issued while reset is held.
  assign ic_req_valid = !rst && (r_state == S_REQ) && !jb &&
                        (!r_hold_valid || w_consume);
  assign ic_req_addr  = r_pc;

  assign F_out_inst = r_hold_valid ? r_hold_inst : NOP_INST;
  assign F_out_pc   = r_hold_valid ? r_hold_pc   : 32'h0000_0000;
  assign waiting    = !r_hold_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_pend_pc    <= 32'h0000_0000;
      r_hold_inst  <= NOP_INST;
      r_hold_pc    <= 32'h0000_0000;
      r_hold_valid <= 1'b0;
    end else begin
      if (w_consume) begin
        r_hold_valid <= 1'b0;
      end

      // Redirect wins over everything else this cycle; a request can never
      // fire together with jb, so the PC writes below do not collide.
      if (jb) begin
        r_pc         <= w_jb_pc;
        r_hold_valid <= 1'b0;
      end

      case (r_state)
        S_REQ: begin
          if (w_req_fire) begin
            r_pend_pc <= r_pc;
            r_pc      <= r_pc + 32'd4;  // wraps silently at the top
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ic_resp_valid) begin
            if (!jb) begin
              r_hold_inst  <= ic_resp_data;
              r_hold_pc    <= r_pend_pc;
              r_hold_valid <= 1'b1;
            end
            r_state <= S_REQ;
          end else if (jb) begin
            // Response still in flight for the old path; swallow it later.
            r_state <= S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (ic_resp_valid) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF stage of the RV32I cached core.
- Holds the PC and issues one instruction-cache request at a time.
- Buffers the returned instruction until the IF/ID register captures it.
- Drives that register's instruction, PC and waiting inputs; handles branch/jump redirects, including discarding an in-flight cache response.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0013, instruction driven while no valid instruction is held (addi x0,x0,0)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
stall  in  1  hazard unit: IF/ID register holds this cycle
jb  in  1  EX stage: branch taken / jump, redirect fetch
jb_target  in  32  redirect address
ic_req_valid  out  1  cache request valid
ic_req_addr  out  32  cache request address (word aligned)
ic_req_ready  in  1  cache accepts request this cycle
ic_resp_valid  in  1  response data valid (exactly one per accepted request)
ic_resp_data  in  32  fetched instruction
F_out_inst  out  32  instruction to IF/ID register
F_out_pc  out  32  PC of F_out_inst
waiting  out  1  no valid instruction available; IF/ID register holds

Behaviour:
- Reset values:
  - state=S_REQ, pc=RESET_PC, hold_valid=0.
  - ic_req_valid=0 in the reset cycle and until rst deasserts.
  - F_out_inst=NOP_INST, F_out_pc=0, waiting=1.
- Outputs (combinational from registers only):
  - hold_valid=1: F_out_inst=hold_inst, F_out_pc=hold_pc, waiting=0.
  - hold_valid=0: F_out_inst=NOP_INST, F_out_pc=0, waiting=1.
- Consume: hold_valid && !stall && !jb. hold_valid clears at the next edge.
- States:
  - S_REQ:
    - ic_req_valid = !jb && (!hold_valid || consume); ic_req_addr=pc.
    - On accept (valid&&ready): pend_pc<=pc, pc<=pc+4 (mod 2^32), go to S_WAIT.
    - Not accepted: stay, pc unchanged.
  - S_WAIT:
    - ic_req_valid=0.
    - On ic_resp_valid && !jb: hold_inst<=ic_resp_data, hold_pc<=pend_pc, hold_valid<=1, go to S_REQ.
    - On jb && ic_resp_valid: response dropped, go to S_REQ.
    - On jb && !ic_resp_valid: go to S_DISCARD.
  - S_DISCARD:
    - ic_req_valid=0.
    - On ic_resp_valid: data dropped, go to S_REQ.
    - jb here only updates pc.
- Redirect (any state): jb=1 sets pc<=jb_target with bits[1:0] forced 0, and hold_valid<=0.
- Priority: jb has priority over stall and over every other transition in that cycle.
- Only one outstanding request; ic_req_addr is stable while ic_req_valid=1 and not accepted, unless jb changes pc.
- Throughput: 2 cycles per instruction with a 1-cycle cache hit; miss latency is passed through as waiting=1.
- Stall with hold_valid=1: hold is kept and no new request is issued.
- Reset mid-miss: the state machine returns to S_REQ. The cache is reset by the same rst, so no stale response can arrive.
- PC wraps from 32'hFFFF_FFFC to 0 without a flag.

Decomposition:
- Shared core package holds:
  - fetch state enum {S_REQ, S_WAIT, S_DISCARD}
  - NOP_INST constant (also used by the IF/ID flush path)
  - RESET_PC default
- Single module; no sub-module. PC register, state machine and hold buffer are all in-line.

Test Plan:
- Reset, cache ready with 1-cycle hits, memory[0]=32'h00500093, [4]=32'h00A00113:
  - waiting=1 while reset.
  - Req addr 0 in cycle 1, F_out_inst=00500093/pc 0 in cycle 3.
  - Req addr 4 in cycle 3.
- stall=1 for 3 cycles while holding pc 4:
  - F_out_inst/pc held, waiting=0, no ic_req_valid.
  - Request for 8 issues in the cycle stall drops.
- Miss: ic_resp_valid 6 cycles after the request to 0x10:
  - waiting=1 throughout.
  - Instruction appears with pc 0x10 one cycle after the response.
- jb=1, target 0x40, in S_WAIT with the response 3 cycles later:
  - Late response discarded (never on F_out).
  - Next request addr 0x40; F_out_pc=0x40.
- jb=1 same cycle as ic_resp_valid, target 0x102 (misaligned):
  - Response dropped, hold cleared.
  - Next request addr 0x100.
- rst asserted mid-miss in S_WAIT:
  - Outputs return to reset values immediately (async).
  - First request after release at RESET_PC.
